// File: rtl/lstm_sequencer.sv
// Initiator-side sequencer for an LSTM cell. It forwards weight/bias writes, seeds h/C,
// issues one x sample at a time and returns each step's y/C on a ready/valid stream.
module lstm_sequencer #(
    parameter int  WIDTH     = 16,
    parameter int  MAX_STEPS = 64,
    parameter int  TIMEOUT   = 15,
    localparam int WEIGHTS   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [1:0]                 cfg_sel,
    input  logic [1:0]                 cfg_gate,
    input  logic [WIDTH-1:0]           cfg_data,
    input  logic                       start,
    input  logic [WIDTH-1:0]           init_h,
    input  logic [WIDTH-1:0]           init_C,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [WIDTH-1:0]           m_y,
    output logic [WIDTH-1:0]           m_C,
    output logic                       m_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       busy,
    output logic                       err,
    output logic [WEIGHTS*WIDTH-1:0]   lstm_weight_x,
    output logic [WEIGHTS*WIDTH-1:0]   lstm_weight_h,
    output logic [WEIGHTS*WIDTH-1:0]   lstm_bias_x,
    output logic [WEIGHTS*WIDTH-1:0]   lstm_bias_h,
    output logic [WEIGHTS-1:0]         lstm_weight_x_valid,
    output logic [WEIGHTS-1:0]         lstm_weight_h_valid,
    output logic [WEIGHTS-1:0]         lstm_bias_x_valid,
    output logic [WEIGHTS-1:0]         lstm_bias_h_valid,
    input  logic                       lstm_ready,
    output logic [WIDTH-1:0]           lstm_x_in,
    output logic [WIDTH-1:0]           lstm_h_in,
    output logic [WIDTH-1:0]           lstm_C_in,
    output logic                       lstm_x_in_valid,
    output logic                       lstm_h_in_valid,
    output logic                       lstm_C_in_valid,
    input  logic [WIDTH-1:0]           lstm_y_out,
    input  logic [WIDTH-1:0]           lstm_C_out,
    input  logic                       lstm_valid
);

    localparam int STEP_W  = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [STEP_W-1:0]  STEP_MAX  = STEP_W'(MAX_STEPS - 1);
    localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t              state;
    logic [WIDTH-1:0]    h_q;
    logic [WIDTH-1:0]    c_q;
    logic                first;
    logic                last;
    logic [STEP_W-1:0]   step;
    logic [TIMER_W-1:0]  timer;

    logic                cfg_fire;
    logic                x_fire;
    logic [WEIGHTS-1:0]  gate_onehot;
    logic [WEIGHTS*WIDTH-1:0] cfg_bus;

    // NOTE: cfg_ready is combinational, so it is masked by rst to keep every output at 0 during reset.
    assign cfg_ready   = !rst && (state == IDLE) && lstm_ready && !start;
    assign cfg_fire    = cfg_valid && cfg_ready;
    assign gate_onehot = WEIGHTS'(1) << cfg_gate;
    assign cfg_bus     = cfg_fire ? {WEIGHTS{cfg_data}} : '0;

    assign lstm_weight_x = cfg_bus;
    assign lstm_weight_h = cfg_bus;
    assign lstm_bias_x   = cfg_bus;
    assign lstm_bias_h   = cfg_bus;

    assign lstm_weight_x_valid = (cfg_fire && cfg_sel == 2'd0) ? gate_onehot : '0;
    assign lstm_weight_h_valid = (cfg_fire && cfg_sel == 2'd1) ? gate_onehot : '0;
    assign lstm_bias_x_valid   = (cfg_fire && cfg_sel == 2'd2) ? gate_onehot : '0;
    assign lstm_bias_h_valid   = (cfg_fire && cfg_sel == 2'd3) ? gate_onehot : '0;

    // h/C are only presented alongside the very first sample; the cell keeps its own state afterwards.
    assign s_ready         = (state == ISSUE) && lstm_ready;
    assign x_fire          = s_ready && s_valid;
    assign lstm_x_in_valid = x_fire;
    assign lstm_h_in_valid = x_fire && first;
    assign lstm_C_in_valid = x_fire && first;
    assign lstm_x_in       = (state == ISSUE) ? s_data : '0;
    assign lstm_h_in       = h_q;
    assign lstm_C_in       = c_q;

    assign busy = (state != IDLE);

    // NOTE: all sequential state is written with non-blocking assignments in this single block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            h_q     <= '0;
            c_q     <= '0;
            first   <= 1'b0;
            last    <= 1'b0;
            step    <= '0;
            timer   <= '0;
            err     <= 1'b0;
            m_y     <= '0;
            m_C     <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        h_q   <= init_h;
                        c_q   <= init_C;
                        first <= 1'b1;
                        step  <= '0;
                        err   <= 1'b0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (x_fire) begin
                        first <= 1'b0;
                        last  <= s_last || (step == STEP_MAX);
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (lstm_valid) begin
                        m_y     <= lstm_y_out;
                        m_C     <= lstm_C_out;
                        m_last  <= last;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else if (timer == TIMER_END) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (step != STEP_MAX) step <= step + 1'b1;
                        state   <= last ? IDLE : ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_sequencer.sv
// Scoreboard bench for lstm_sequencer: a behavioural cell answers 6 cycles after each x,
// expected y/C/last sequences come from iterating the cell function over each sequence.
module tb_lstm_sequencer;

    localparam int W    = 16;
    localparam int MAXS = 64;
    localparam int TO   = 15;
    localparam int LAT  = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic [1:0]     cfg_sel = '0;
    logic [1:0]     cfg_gate = '0;
    logic [W-1:0]   cfg_data = '0;
    logic           start = 1'b0;
    logic [W-1:0]   init_h = '0;
    logic [W-1:0]   init_C = '0;
    logic [W-1:0]   s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           m_ready = 1'b0;
    logic           lstm_ready = 1'b0;
    logic [W-1:0]   lstm_y_out = '0;
    logic [W-1:0]   lstm_C_out = '0;
    logic           lstm_valid = 1'b0;

    logic           cfg_ready, s_ready, m_last, m_valid, busy, err;
    logic [W-1:0]   m_y, m_C, lstm_x_in, lstm_h_in, lstm_C_in;
    logic [4*W-1:0] lstm_weight_x, lstm_weight_h, lstm_bias_x, lstm_bias_h;
    logic [3:0]     lstm_weight_x_valid, lstm_weight_h_valid, lstm_bias_x_valid, lstm_bias_h_valid;
    logic           lstm_x_in_valid, lstm_h_in_valid, lstm_C_in_valid;

    lstm_sequencer #(.WIDTH(W), .MAX_STEPS(MAXS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_gate(cfg_gate),
        .cfg_data(cfg_data), .start(start), .init_h(init_h), .init_C(init_C),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_y(m_y), .m_C(m_C), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .err(err),
        .lstm_weight_x(lstm_weight_x), .lstm_weight_h(lstm_weight_h),
        .lstm_bias_x(lstm_bias_x), .lstm_bias_h(lstm_bias_h),
        .lstm_weight_x_valid(lstm_weight_x_valid), .lstm_weight_h_valid(lstm_weight_h_valid),
        .lstm_bias_x_valid(lstm_bias_x_valid), .lstm_bias_h_valid(lstm_bias_h_valid),
        .lstm_ready(lstm_ready),
        .lstm_x_in(lstm_x_in), .lstm_h_in(lstm_h_in), .lstm_C_in(lstm_C_in),
        .lstm_x_in_valid(lstm_x_in_valid), .lstm_h_in_valid(lstm_h_in_valid),
        .lstm_C_in_valid(lstm_C_in_valid),
        .lstm_y_out(lstm_y_out), .lstm_C_out(lstm_C_out), .lstm_valid(lstm_valid)
    );

    always #5 clk = ~clk;

    logic [15:0] strobes;
    assign strobes = {lstm_weight_x_valid, lstm_weight_h_valid, lstm_bias_x_valid, lstm_bias_h_valid};
    logic [360:0] all_out;
    assign all_out = {cfg_ready, s_ready, m_y, m_C, m_last, m_valid, busy, err,
                      lstm_weight_x, lstm_weight_h, lstm_bias_x, lstm_bias_h, strobes,
                      lstm_x_in, lstm_h_in, lstm_C_in, lstm_x_in_valid, lstm_h_in_valid, lstm_C_in_valid};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in cell: C' = C/2 + x, y = (h ^ x) + C', h' = y.
    function automatic logic [31:0] cell_fn(input logic [W-1:0] h, input logic [W-1:0] c,
                                            input logic [W-1:0] x);
        logic [W-1:0] cn, y;
        cn = {c[W-1], c[W-1:1]} + x;
        y  = (h ^ x) + cn;
        return {y, cn};
    endfunction

    typedef struct { logic [W-1:0] x; logic last; } samp_t;
    samp_t       samp_q[$];
    logic [32:0] exp_q[$];

    bit          ready_rand = 1'b0;
    bit          mr_rand    = 1'b0;
    bit          cell_mute  = 1'b0;
    int          stall_cnt  = 0;
    int          cyc        = 0;
    bit          exp_first  = 1'b0;
    bit          cell_pending = 1'b0;
    int          cell_due   = 0;
    logic [W-1:0] cell_h = '0, cell_c = '0, cell_y = '0, cell_co = '0;
    int          last_x_cyc = 0;
    int          mhs_cyc    = 0;
    int          x_count    = 0;

    // Input driver: everything the environment owns changes 1 time unit after the rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        lstm_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (cell_pending && !cell_mute && cyc == cell_due) begin
            lstm_valid = 1'b1;
            lstm_y_out = cell_y;
            lstm_C_out = cell_co;
        end else begin
            lstm_valid = 1'b0;
            lstm_y_out = W'($urandom);
            lstm_C_out = W'($urandom);
        end
        if (samp_q.size() > 0 && (!ready_rand || $urandom_range(0, 4) != 0)) begin
            s_valid = 1'b1;
            s_data  = samp_q[0].x;
            s_last  = samp_q[0].last;
        end else begin
            s_valid = 1'b0;
            s_data  = W'($urandom);
            s_last  = 1'($urandom);
        end
        if (m_valid && stall_cnt > 0) begin
            m_ready = 1'b0;
            stall_cnt--;
        end else begin
            m_ready = mr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor, cell model and scoreboard, sampled mid-cycle.
    logic         prev_mv = 1'b0, prev_mr = 1'b0, prev_l = 1'b0;
    logic [W-1:0] prev_y = '0, prev_c = '0;
    always @(negedge clk) begin
        logic [31:0] r;
        logic [32:0] e;
        if (rst) begin
            prev_mv = 1'b0;
            prev_mr = 1'b0;
        end else begin
            if (prev_mv && !prev_mr)
                check("out_hold", 128'({m_valid, m_y, m_C, m_last}), 128'({1'b1, prev_y, prev_c, prev_l}));
            if (m_valid && !prev_mv)
                check("latency", 128'(cyc - last_x_cyc), 128'(LAT));
            if (m_valid)
                check("no_issue_in_out", 128'({s_ready, lstm_x_in_valid}), 128'(0));
            if ((s_valid && s_ready) || lstm_x_in_valid) begin
                check("x_handshake", 128'({s_valid && s_ready, lstm_x_in_valid, lstm_x_in}),
                      128'({2'b11, s_data}));
                check("hc_strobe", 128'({lstm_h_in_valid, lstm_C_in_valid}), 128'({exp_first, exp_first}));
                if (samp_q.size() > 0) void'(samp_q.pop_front());
                if (lstm_h_in_valid) cell_h = lstm_h_in;
                if (lstm_C_in_valid) cell_c = lstm_C_in;
                r = cell_fn(cell_h, cell_c, lstm_x_in);
                cell_h = r[31:16];
                cell_c = r[15:0];
                cell_y = r[31:16];
                cell_co = r[15:0];
                cell_pending = 1'b1;
                cell_due = cyc + 6;
                last_x_cyc = cyc;
                exp_first = 1'b0;
                x_count++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 128'({m_y, m_C, m_last}), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("result", 128'({m_y, m_C, m_last}), 128'(e));
                end
                mhs_cyc = cyc;
            end
            prev_mv = m_valid;
            prev_mr = m_ready;
            prev_y  = m_y;
            prev_c  = m_C;
            prev_l  = m_last;
        end
    end

    task automatic cfg_write(input logic [1:0] sel, input logic [1:0] gate, input logic [W-1:0] data);
        logic [15:0]  exp_s;
        logic [63:0]  bus;
        bit           done;
        int           g;
        int           sl;
        g = int'(gate);
        sl = int'(sel);
        done = 1'b0;
        exp_s = 16'h0001 << (g + 4 * (3 - sl));
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_sel = sel; cfg_gate = gate; cfg_data = data;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            check("cfg_ready", 128'(cfg_ready), 128'(lstm_ready));
            if (cfg_ready) begin
                case (sel)
                    2'd0:    bus = lstm_weight_x;
                    2'd1:    bus = lstm_weight_h;
                    2'd2:    bus = lstm_bias_x;
                    default: bus = lstm_bias_h;
                endcase
                check("cfg_strobe", 128'(strobes), 128'(exp_s));
                check("cfg_slice", 128'(bus[g*W +: W]), 128'(data));
                done = 1'b1;
            end else begin
                check("cfg_strobe_idle", 128'(strobes), 128'(0));
                @(posedge clk); #1;
            end
        end
        if (!done) check("cfg_accept_timeout", 128'(0), 128'(1));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_data  = W'($urandom);
        @(negedge clk);
        check("cfg_pulse_end", 128'(strobes), 128'(0));
    endtask

    task automatic run_seq(input int n, input logic [W-1:0] ih, input logic [W-1:0] ic,
                           input bit stray, input bit collide, input bit x0_en,
                           input logic [W-1:0] x0, input bit no_last);
        samp_t        s;
        logic [W-1:0] h, c;
        logic [31:0]  r;
        int           budget;
        h = ih;
        c = ic;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            s.x    = (k == 0 && x0_en) ? x0 : W'($urandom);
            s.last = !no_last && (k == n - 1);
            samp_q.push_back(s);
            r = cell_fn(h, c, s.x);
            exp_q.push_back({r, s.last || (k == MAXS - 1)});
            h = r[31:16];
            c = r[15:0];
        end
        start = 1'b1; init_h = ih; init_C = ic; exp_first = 1'b1;
        if (collide) begin
            cfg_valid = 1'b1; cfg_sel = 2'($urandom); cfg_gate = 2'($urandom); cfg_data = W'($urandom);
        end
        @(negedge clk);
        if (collide) check("start_beats_cfg", 128'({cfg_ready, strobes}), 128'(0));
        @(posedge clk); #1;
        start = 1'b0;
        cfg_valid = 1'b0;
        check("busy_after_start", 128'({busy, err}), 128'(2'b10));
        for (budget = 0; budget < n * 60 + 100; budget++) begin
            if (!busy && exp_q.size() == 0) break;
            @(posedge clk); #1;
            start = stray && busy && ($urandom_range(0, 7) == 0);
            if (start) begin
                init_h = W'($urandom);
                init_C = W'($urandom);
            end
        end
        start = 1'b0;
        if (busy || exp_q.size() != 0) begin
            check("seq_done_timeout", 128'(exp_q.size()), 128'(0));
            exp_q.delete();
            samp_q.delete();
        end else begin
            check("busy_fall", 128'(cyc - mhs_cyc), 128'(1));
            check("samples_consumed", 128'(samp_q.size()), 128'(0));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        samp_t s;
        int    xc;
        int    hs;
        bit    seen;

        repeat (3) @(negedge clk);
        check("reset_outputs", 128'(|all_out), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        cfg_write(2'd0, 2'd2, 16'h0100);
        cfg_write(2'd1, 2'd0, 16'hFF80);
        cfg_write(2'd2, 2'd3, 16'h0040);
        cfg_write(2'd3, 2'd1, 16'h8000);

        run_seq(1, 16'h0080, 16'hFF00, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0);
        run_seq(3, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, '0, 1'b0);

        stall_cnt = 10;
        run_seq(2, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Cell never answers: the sequencer must give up after TO WAIT cycles.
        cell_mute = 1'b1;
        xc = x_count;
        @(posedge clk); #1;
        s.x = W'($urandom);
        s.last = 1'b1;
        samp_q.push_back(s);
        start = 1'b1; init_h = W'($urandom); init_C = W'($urandom); exp_first = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (x_count != xc);
        end
        check("timeout_issue_seen", 128'(seen), 128'(1));
        hs = last_x_cyc;
        for (int i = 0; i < 40 && cyc < hs + TO; i++) @(negedge clk);
        check("before_timeout", 128'({busy, err}), 128'(2'b10));
        @(negedge clk);
        check("timeout_err", 128'({busy, err, m_valid}), 128'(3'b010));
        repeat (5) @(negedge clk);
        check("err_sticky", 128'({busy, err}), 128'(2'b01));
        cell_mute = 1'b0;
        cell_pending = 1'b0;
        samp_q.delete();
        run_seq(2, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("err_cleared_by_start", 128'(err), 128'(0));

        run_seq(MAXS, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Reset in WAIT: outputs drop at once and configuration is accepted afterwards.
        xc = x_count;
        @(posedge clk); #1;
        s.x = W'($urandom);
        s.last = 1'b1;
        samp_q.push_back(s);
        start = 1'b1; init_h = W'($urandom); init_C = W'($urandom); exp_first = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (x_count != xc);
        end
        check("rst_issue_seen", 128'(seen), 128'(1));
        repeat (2) @(negedge clk);
        check("in_wait_before_rst", 128'({busy, m_valid}), 128'(2'b10));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("reset_in_wait", 128'(|all_out), 128'(0));
        samp_q.delete();
        exp_q.delete();
        cell_pending = 1'b0;
        exp_first = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_write(2'd3, 2'd3, 16'h7FFF);

        ready_rand = 1'b1;
        mr_rand    = 1'b1;
        for (int t = 0; t < 25; t++) begin
            cfg_write(2'($urandom), 2'($urandom), W'($urandom));
            run_seq($urandom_range(1, 6), W'($urandom), W'($urandom), 1'b1, 1'b0, 1'b0, '0, 1'b0);
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
